// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO on the CPU data bus.
// Output register with set/clear/toggle aliases, synchronised inputs and,
// when GPIO_IRQ_EN is defined, per-bit rising-edge interrupt capture.
// Without GPIO_IRQ_EN the IRQ_EN/IRQ_STAT offsets read 0 and irq is tied low.
module mmio_gpio #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [31:0]      BASE_ADDR = 32'h20000000,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wen,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             irq
);

  logic             sel;
  logic             wrEn;
  logic [2:0]       regIdx;
  logic [31:0]      laneMask;
  logic [31:0]      wdataM;
  logic [WIDTH-1:0] laneW;
  logic [WIDTH-1:0] dataW;
  logic             unusedBits;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [31:0]      rdata_q, rdata_d;

  assign sel      = (addr[31:5] == BASE_ADDR[31:5]);
  assign regIdx   = addr[4:2];
  assign wrEn     = sel & (|wen);
  assign laneMask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  assign wdataM   = wdata & laneMask;
  assign laneW    = laneMask[WIDTH-1:0];
  assign dataW    = wdataM[WIDTH-1:0];

  // Byte offset bits and data lanes above WIDTH have no destination.
  assign unusedBits = ^{addr[1:0], laneMask, wdataM};

  // Output register next state: plain write or one of the atomic aliases.
  always_comb begin
    out_d = out_q;
    if (wrEn) begin
      case (regIdx)
        3'd0:    out_d = (out_q & ~laneW) | (dataW & laneW);
        3'd1:    out_d = out_q | dataW;
        3'd2:    out_d = out_q & ~dataW;
        3'd3:    out_d = out_q ^ dataW;
        default: out_d = out_q;
      endcase
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= OUT_RESET;
    else     out_q <= out_d;
  end

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= gpio_in;
      s2_q <= s1_q;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] w1cMask;

  assign rise = s2_q & ~prev_q & en_q;

  // Enable register write and status W1C; a fresh edge beats a clear.
  always_comb begin
    en_d    = en_q;
    w1cMask = '0;
    if (wrEn && regIdx == 3'd5) en_d = (en_q & ~laneW) | (dataW & laneW);
    if (wrEn && regIdx == 3'd6) w1cMask = dataW;
    stat_d = (stat_q & ~w1cMask) | rise;
  end

  // Interrupt enable, status and edge-history state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= '0;
      stat_q <= '0;
      prev_q <= '0;
    end else begin
      en_q   <= en_d;
      stat_q <= stat_d;
      prev_q <= s2_q;
    end
  end

  assign irq = |(stat_q & en_q);
`else
  assign irq = 1'b0;
`endif

  // Read mux; alias, reserved and unselected addresses return 0.
  always_comb begin
    rdata_d = '0;
    if (sel) begin
      case (regIdx)
        3'd0:    rdata_d = 32'(out_q);
        3'd4:    rdata_d = 32'(s2_q);
`ifdef GPIO_IRQ_EN
        3'd5:    rdata_d = 32'(en_q);
        3'd6:    rdata_d = 32'(stat_q);
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  // Registered read data, one cycle behind the address like the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata    = rdata_q;
  assign gpio_out = out_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: scoreboard bench for mmio_gpio (WIDTH=16, OUT_RESET=0xA).
// Expectations for the interrupt registers follow whether GPIO_IRQ_EN is set.
module tb_mmio_gpio;

  localparam int unsigned W    = 16;
  localparam logic [31:0] BASE = 32'h20000000;
`ifdef GPIO_IRQ_EN
  localparam bit HasIrq = 1'b1;
`else
  localparam bit HasIrq = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [3:0]    wen;
  logic [31:0]   rdata;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic          irq;

  int            total = 0;
  int            bad   = 0;
  bit            rdPending = 1'b0;
  logic [31:0]   expQ[$];
  string         tagQ[$];

  mmio_gpio #(
    .WIDTH    (W),
    .BASE_ADDR(BASE),
    .OUT_RESET(16'h000A)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .wen     (wen),
    .rdata   (rdata),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Drive one bus cycle at the falling edge; reads queue their expected data.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] w, input bit isRead,
                               input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr      = a;
    wdata     = d;
    wen       = w;
    rdPending = isRead;
    if (isRead) begin
      expQ.push_back(exp);
      tagQ.push_back(tag);
    end
    @(posedge clk);
    #2;
    addr      = 32'h0;
    wdata     = 32'h0;
    wen       = 4'h0;
    rdPending = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] off, input logic [31:0] d, input logic [3:0] w);
    applyStimulus(BASE + 32'(off), d, w, 1'b0, 32'h0, "");
  endtask

  task automatic readReg(input logic [4:0] off, input logic [31:0] exp, input string tag);
    applyStimulus(BASE + 32'(off), 32'h0, 4'h0, 1'b1, exp, tag);
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 32'h0, "");
  endtask

  // Monitor: rdata produced one edge after a queued read is compared here.
  initial begin
    forever begin
      @(posedge clk);
      if (rdPending) begin
        #1;
        if (expQ.size() == 0) begin
          checkOutput("scoreboard_underflow", 32'h1, 32'h0);
        end else begin
          checkOutput(tagQ.pop_front(), rdata, expQ.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    addr    = 32'h0;
    wdata   = 32'h0;
    wen     = 4'h0;
    gpio_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_gpio_out", 32'(gpio_out), 32'h0000_000A);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    readReg(5'h00, 32'h0000_000A, "rd_out_reset");

    // Output register and atomic aliases.
    writeReg(5'h00, 32'h5, 4'b1111);
    checkOutput("out_write", 32'(gpio_out), 32'h5);
    writeReg(5'h04, 32'h8, 4'b1111);
    checkOutput("out_set", 32'(gpio_out), 32'hD);
    readReg(5'h04, 32'h0, "rd_set_alias");
    writeReg(5'h08, 32'h1, 4'b1111);
    checkOutput("out_clr", 32'(gpio_out), 32'hC);
    writeReg(5'h0C, 32'h6, 4'b1111);
    checkOutput("out_tgl", 32'(gpio_out), 32'hA);
    readReg(5'h00, 32'hA, "rd_out_after_tgl");

    // Byte lanes and bits above WIDTH.
    writeReg(5'h00, 32'h0, 4'b1111);
    writeReg(5'h00, 32'hABCD, 4'b0001);
    checkOutput("lane0_only", 32'(gpio_out), 32'h00CD);
    writeReg(5'h00, 32'hFFFF_FFFF, 4'b0010);
    readReg(5'h00, 32'hFFCD, "rd_lane1");
    writeReg(5'h00, 32'hFFFF_FFFF, 4'b1100);
    readReg(5'h00, 32'hFFCD, "rd_upper_lanes");
    writeReg(5'h04, 32'hFFFF_0000, 4'b1111);
    checkOutput("set_above_width", 32'(gpio_out), 32'hFFCD);

    // Out-of-window addresses neither write nor read.
    applyStimulus(32'h2000_0020, 32'h0, 4'b1111, 1'b1, 32'h0, "rd_above_window");
    applyStimulus(32'h1000_0000, 32'h0, 4'b1111, 1'b1, 32'h0, "rd_other_window");
    checkOutput("no_write_outside", 32'(gpio_out), 32'hFFCD);

    // Read-after-write and reserved offset.
    writeReg(5'h00, 32'h1234, 4'b1111);
    readReg(5'h00, 32'h1234, "rd_after_write");
    writeReg(5'h1C, 32'hFFFF_FFFF, 4'b1111);
    readReg(5'h1C, 32'h0, "rd_reserved");
    writeReg(5'h10, 32'hFFFF_FFFF, 4'b1111);
    readReg(5'h10, 32'h0, "rd_in_idle");

    // Rising edge on bit 0: IN after 2 edges, status and irq after 3.
    writeReg(5'h14, 32'h1, 4'b1111);
    readReg(5'h14, HasIrq ? 32'h1 : 32'h0, "rd_irq_en");
    gpio_in = 16'h0001;
    readReg(5'h10, 32'h0, "in_edge1");
    readReg(5'h10, 32'h0, "in_edge2");
    checkOutput("irq_before_capture", 32'(irq), 32'h0);
    readReg(5'h10, 32'h1, "in_edge3");
    checkOutput("irq_after_capture", 32'(irq), HasIrq ? 32'h1 : 32'h0);
    readReg(5'h18, HasIrq ? 32'h1 : 32'h0, "rd_stat_captured");
    writeReg(5'h18, 32'h1, 4'b1111);
    checkOutput("irq_after_w1c", 32'(irq), 32'h0);
    readReg(5'h18, 32'h0, "rd_stat_cleared");

    // Recapture, then collide a W1C with a fresh edge: set must win.
    gpio_in = 16'h0000;
    repeat (3) idle();
    gpio_in = 16'h0001;
    repeat (3) idle();
    checkOutput("irq_recapture", 32'(irq), HasIrq ? 32'h1 : 32'h0);
    gpio_in = 16'h0000;
    repeat (3) idle();
    gpio_in = 16'h0001;
    idle();
    idle();
    writeReg(5'h18, 32'h1, 4'b1111);
    checkOutput("irq_set_wins", 32'(irq), HasIrq ? 32'h1 : 32'h0);
    readReg(5'h18, HasIrq ? 32'h1 : 32'h0, "rd_stat_set_wins");

    // Dropping the enable masks irq but keeps status.
    writeReg(5'h14, 32'h0, 4'b1111);
    checkOutput("irq_masked", 32'(irq), 32'h0);
    readReg(5'h18, HasIrq ? 32'h1 : 32'h0, "rd_stat_masked");

    // Reset in the middle of a write discards it.
    @(negedge clk);
    addr  = BASE;
    wdata = 32'hFFFF;
    wen   = 4'b1111;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_gpio_out", 32'(gpio_out), 32'h000A);
    checkOutput("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    wen   = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;
    rst   = 1'b0;
    readReg(5'h14, 32'h0, "rd_en_after_rst");
    repeat (3) idle();
    checkOutput("irq_after_rst_edge", 32'(irq), 32'h0);
    readReg(5'h18, 32'h0, "rd_stat_after_rst");
    readReg(5'h10, 32'h1, "rd_in_after_rst");

    idle();
    if (expQ.size() != 0) checkOutput("scoreboard_leftover", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
